// File: rtl/dataflow_tb_pkg.sv
// dataflow_tb_pkg: shared FSM state type, default widths and saturating increment.
package dataflow_tb_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_DATA_W = 10;
  localparam int DEF_CNT_W = 32;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    return (v == max_v) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/result_collector_sat_counter.sv
// sat_counter: clearable, enabled, saturating up-counter (clear has priority).
module sat_counter import dataflow_tb_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? CNT_W'(sat_inc(64'(cnt_q), CNT_W)) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign q = cnt_q;
endmodule

// File: rtl/result_collector.sv
// result_collector: captures one kernel result per run, measures latency, drains extra tokens.
// Optional watchdog enabled by defining RESULT_COLLECTOR_TIMEOUT_EN.
module result_collector import dataflow_tb_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic [CNT_W-1:0]  cycles,
  output logic [CNT_W-1:0]  extra_cnt,
  output logic              error,
  output logic              timeout,
  input  logic              ack
);
  state_t state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic timeout_q, timeout_d, error_q, error_d;
  logic xfer, tmo;
  assign in_ready = (state_q == IDLE) ? start : 1'b1;
  assign xfer = in_valid & in_ready;
`ifdef RESULT_COLLECTOR_TIMEOUT_EN
  assign tmo = (state_q == RUN) && (cycles == CNT_W'(TIMEOUT_CYCLES - 1)) && !xfer;
`else
  // watchdog absent: the parameter is accepted but never fires
  assign tmo = (TIMEOUT_CYCLES < 0);
`endif
  always_comb begin
    state_d = state_q;
    result_d = result_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        state_d = !start ? IDLE : xfer ? DONE : RUN;
        result_d = xfer ? in_data : result_q;
      end
      RUN: begin
        state_d = (xfer || tmo) ? DONE : RUN;
        result_d = xfer ? in_data : result_q;
        timeout_d = tmo;
      end
      DONE: begin
        state_d = ack ? IDLE : DONE;
        result_d = ack ? '0 : result_q;
        timeout_d = timeout_q & !ack;
      end
      default: state_d = IDLE;
    endcase
    error_d = error_q | ((state_q == DONE) && xfer);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      result_q <= '0;
      timeout_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      timeout_q <= timeout_d;
      error_q <= error_d;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_cycles (
    .clk(clk), .rst(rst),
    .clr(((state_q == IDLE) && start) || ((state_q == DONE) && ack)),
    .en(state_q == RUN), .q(cycles)
  );
  sat_counter #(.CNT_W(CNT_W)) u_extra (
    .clk(clk), .rst(rst), .clr(1'b0),
    .en((state_q == DONE) && xfer), .q(extra_cnt)
  );
  assign result = result_q;
  assign done = (state_q == DONE);
  assign timeout = timeout_q;
  assign error = error_q;
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: vector table of runs plus scoreboard of expected captures.
module tb_result_collector;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, ack = 0;
  logic [9:0] in_data = '0;
  logic in_ready, done, error, timeout;
  logic [9:0] result;
  logic [31:0] cycles, extra_cnt;
  int n_tests = 0, n_fail = 0;

  typedef struct {
    int delay;
    logic [9:0] data;
    int n_extra;
    logic ack_tok;
    logic [31:0] exp_cycles;
    logic [31:0] exp_extra;
    logic exp_err;
  } vec_t;
  typedef struct {
    logic [9:0] data;
    logic [31:0] cyc;
  } sb_t;
  vec_t vecs[4];
  sb_t sb[$];

  result_collector #(.DATA_W(10), .CNT_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .result(result), .done(done), .cycles(cycles),
    .extra_cnt(extra_cnt), .error(error), .timeout(timeout), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic run_one(input vec_t v);
    sb_t e;
    logic [31:0] post_extra;
    @(negedge clk);
    start = 1;
    if (v.delay == 0) begin
      in_valid = 1;
      in_data = v.data;
    end
    #1 chk("in_ready_idle_start", in_ready, 1);
    sb.push_back('{v.data, v.exp_cycles});
    @(negedge clk);
    start = 0;
    in_valid = 0;
    for (int i = 1; i < v.delay; i++) begin
      if (i == 1) chk("in_ready_run", in_ready, 1);
      start = (i == 1 && v.delay >= 3);
      ack = (i == 1 && v.delay >= 3);
      in_data = 10'($urandom);
      @(negedge clk);
    end
    start = 0;
    ack = 0;
    if (v.delay > 0) begin
      in_valid = 1;
      in_data = v.data;
      @(negedge clk);
      in_valid = 0;
    end
    wait_done(10);
    if (sb.size() == 0) chk("sb_nonempty", 0, 1);
    else begin
      e = sb.pop_front();
      chk("result", result, e.data);
      chk("cycles", cycles, e.cyc);
      chk("timeout_clear", timeout, 0);
    end
    for (int i = 0; i < v.n_extra; i++) begin
      in_valid = 1;
      in_data = 10'($urandom);
      @(negedge clk);
    end
    in_valid = 0;
    chk("extra_cnt", extra_cnt, v.exp_extra);
    chk("error", error, v.exp_err);
    chk("result_held", result, v.data);
    ack = 1;
    in_valid = v.ack_tok;
    @(negedge clk);
    ack = 0;
    in_valid = 0;
    post_extra = v.exp_extra + 32'(v.ack_tok);
    chk("done_after_ack", done, 0);
    chk("result_after_ack", result, 0);
    chk("cycles_after_ack", cycles, 0);
    chk("extra_retained", extra_cnt, post_extra);
    chk("error_retained", error, (post_extra != 0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecs[0] = '{5, 10'h2A, 0, 1'b0, 32'd5, 32'd0, 1'b0};
    vecs[1] = '{0, 10'h3FF, 3, 1'b0, 32'd0, 32'd3, 1'b1};
    vecs[2] = '{1, 10'h155, 0, 1'b0, 32'd1, 32'd3, 1'b1};
    vecs[3] = '{3, 10'h0AA, 1, 1'b1, 32'd3, 32'd4, 1'b1};
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_result", result, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_extra", extra_cnt, 0);
    chk("rst_error", error, 0);
    chk("rst_timeout", timeout, 0);
    for (int i = 0; i < 4; i++) run_one(vecs[i]);
`ifdef RESULT_COLLECTOR_TIMEOUT_EN
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done(20);
    chk("tmo_flag", timeout, 1);
    chk("tmo_cycles", cycles, 8);
    chk("tmo_result", result, 0);
    in_valid = 1;
    in_data = 10'h123;
    @(negedge clk);
    in_valid = 0;
    chk("tmo_late_extra", extra_cnt, 6);
    ack = 1;
    @(negedge clk);
    ack = 0;
    chk("tmo_ack_clear", timeout, 0);
    run_one('{8, 10'h2C3, 0, 1'b0, 32'd8, 32'd6, 1'b1});
`else
    run_one('{20, 10'h2C3, 0, 1'b0, 32'd20, 32'd5, 1'b1});
`endif
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    in_valid = 1;
    in_data = 10'h1FF;
    @(negedge clk);
    rst = 0;
    #1;
    chk("abort_done", done, 0);
    chk("abort_cycles", cycles, 0);
    chk("abort_extra", extra_cnt, 0);
    chk("abort_error", error, 0);
    chk("abort_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    chk("pending_unaccepted", in_ready, 0);
    chk("pending_no_done", done, 0);
    start = 1;
    #1 chk("pending_ready_on_start", in_ready, 1);
    @(negedge clk);
    start = 0;
    in_valid = 0;
    chk("restart_done", done, 1);
    chk("restart_result", result, 10'h1FF);
    chk("restart_cycles", cycles, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Output-side counterpart of the one-shot start gate on a wrapped dataflow kernel.
- Accepts exactly one result token from the kernel's out0 valid/ready channel after a run starts, and latches it for the host.
- Measures start-to-result latency in cycles, then raises done.
- Drains and counts any spurious extra tokens so the kernel never deadlocks.

Parameters:
- DATA_W, 10, width of the result token.
- CNT_W, 32, width of the latency and extra-token counters.
- TIMEOUT_CYCLES, 1000000, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  one-cycle pulse; the kernel's input token was accepted (run begins).
- in_data  in  DATA_W  kernel result data.
- in_valid  in  1  kernel result valid.
- in_ready  out  1  collector ready for the result.
- result  out  DATA_W  latched result.
- done  out  1  result (or timeout) available; level signal.
- cycles  out  CNT_W  latency from start to capture.
- extra_cnt  out  CNT_W  tokens discarded after capture.
- error  out  1  sticky; set when any extra token is discarded.
- timeout  out  1  watchdog fired; constant 0 without the optional feature.
- ack  in  1  host acknowledge; rearms the collector.

Behaviour:
- Reset values: state IDLE; all outputs and counters 0; in_ready 0.
- FSM states: IDLE, RUN, DONE.
- in_ready is combinational: 1 in RUN, 1 in DONE (drain), and equal to start in IDLE.
- Transfer occurs when in_valid and in_ready are both 1 on a clock edge.
- IDLE:
  - start=1 moves to RUN and clears cycles.
  - If a transfer also occurs in that cycle, go straight to DONE with cycles=0 (zero-latency kernel).
  - start while not in IDLE is ignored.
- RUN:
  - cycles increments every cycle and saturates at 2^CNT_W-1.
  - On transfer: result<=in_data, cycles holds the count at the capture edge, done<=1 next cycle, go to DONE.
  - Latency definition: capture k cycles after the start edge reports cycles=k.
- DONE:
  - result and cycles held; in_ready=1.
  - Each transfer increments extra_cnt (saturating) and sets error.
  - ack=1 moves to IDLE and clears done, result, cycles and timeout. extra_cnt and error are NOT cleared by ack; only rst clears them.
  - ack together with a transfer in the same cycle: the token is still counted, then the block moves to IDLE.
- ack outside DONE is ignored.
- start and ack in the same cycle in DONE: ack wins; start is lost (host must not do this).
- in_data is ignored unless a transfer occurs; no X propagates to result.
- rst mid-run aborts the run immediately: back to IDLE, all outputs 0, any pending token dropped.

Optional Feature:
- Macro: RESULT_COLLECTOR_TIMEOUT_EN.
- With the macro:
  - In RUN, when cycles reaches TIMEOUT_CYCLES without a transfer, go to DONE with done=1, timeout=1, result=0, cycles=TIMEOUT_CYCLES.
  - A transfer in that same cycle takes priority: normal capture, timeout=0.
  - After a timeout, a late result arriving in DONE counts as an extra token.
- Without the macro: no watchdog logic, timeout tied to 0, RUN waits forever.

Decomposition:
- Shared package (dataflow_tb_pkg) holds:
  - FSM state typedef {IDLE, RUN, DONE}.
  - Default DATA_W and CNT_W constants.
  - A saturating-increment function, shared by cycles and extra_cnt.
- One natural sub-module: sat_counter (CNT_W, clear/enable/saturate), instantiated twice.
- Remaining FSM and datapath live in result_collector.

Test Plan:
- Reset, start pulse, kernel asserts in_valid with in_data=10'h2A five cycles after start -> in_ready high during RUN; result=0x2A, cycles=5, done=1 one cycle after capture; error=0.
- start and in_valid=1 (data 10'h3FF) in the same IDLE cycle -> in_ready=1 that cycle; done=1 next cycle with result=0x3FF, cycles=0.
- In DONE, the kernel sends 3 more tokens, then ack -> extra_cnt=3, error=1, result unchanged before ack; after ack done=0 and result=0 while extra_cnt and error are retained; a second run captures normally.
- rst asserted two cycles into RUN with in_valid pending -> next cycle all outputs 0, state IDLE; a token held valid stays unaccepted (in_ready=0) until a new start.
- With RESULT_COLLECTOR_TIMEOUT_EN and TIMEOUT_CYCLES=8, no result -> done=1, timeout=1, cycles=8 in DONE; a later token increments extra_cnt.
- With the macro, result arriving exactly at cycle 8 -> normal capture, timeout=0, cycles=8.
